// File: rtl/dense_layer_seq.sv
// Sequential dense layer: result[b][m] = sum_n weights[m][n]*inputs[b][n], LANES MACs per cycle.
// Latency: N/LANES MAC cycles per element, plus 1 cycle in OUT when out_ready is already high.
// Backpressure: out_data/out_b/out_m hold in OUT until out_valid && out_ready, for any duration.
// Optional feature: define DENSE_RELU_EN to clamp negative saturated results to 0.
module dense_layer_seq #(
  parameter int B     = 2,
  parameter int M     = 3,
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  localparam int BW   = (B > 1) ? $clog2(B) : 1,
  localparam int MW   = (M > 1) ? $clog2(M) : 1,
  localparam int DW   = 2 * WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] weights [M][N],
  input  logic signed [WIDTH-1:0] inputs  [B][N],
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DW-1:0]    out_data,
  output logic [BW-1:0]           out_b,
  output logic [MW-1:0]           out_m,
  output logic                    done
);

  // Accumulator carries log2(N)+1 guard bits so a full dot product cannot wrap.
  localparam int AW = DW + $clog2(N) + 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = AW - DW + 1;

  localparam logic [JW-1:0] J_LAST = JW'(N - LANES);
  localparam logic [MW-1:0] M_LAST = MW'(M - 1);
  localparam logic [BW-1:0] B_LAST = BW'(B - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT, DONE} state_t;

  state_t                 state;
  logic signed [AW-1:0]   acc;
  logic [JW-1:0]          j;
  logic [BW-1:0]          b_idx;
  logic [MW-1:0]          m_idx;

  logic signed [DW-1:0]   prod [LANES];
  logic signed [AW-1:0]   lane_sum;
  logic signed [AW-1:0]   acc_next;
  logic [HW-1:0]          acc_hi;
  logic [DW-1:0]          sat_val;
  logic [DW-1:0]          res_val;

  // One full-precision signed product per lane for the current lane group.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [JW-1:0] idx;
    assign idx     = j + JW'(l);
    assign prod[l] = weights[m_idx][idx] * inputs[b_idx][idx];
  end

  // Sign-extend and add the lane products onto the running accumulator.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = lane_sum + AW'(prod[l]);
    end
    acc_next = acc + lane_sum;
  end

  // Clamp to the 2*WIDTH signed range: overflow when the bits above the output sign disagree.
  always_comb begin
    acc_hi  = acc_next[AW-1:DW-1];
    sat_val = acc_next[DW-1:0];
    if (!((&acc_hi) || !(|acc_hi))) begin
      sat_val = acc_next[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
`ifdef DENSE_RELU_EN
    res_val = sat_val[DW-1] ? '0 : sat_val;
`else
    res_val = sat_val;
`endif
  end

  // Control FSM with registered outputs; reset aborts any job without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_b     <= '0;
      out_m     <= '0;
      acc       <= '0;
      j         <= '0;
      b_idx     <= '0;
      m_idx     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          acc   <= '0;
          j     <= '0;
          b_idx <= '0;
          m_idx <= '0;
          if (start) begin
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (j == J_LAST) begin
            out_valid <= 1'b1;
            out_data  <= res_val;
            out_b     <= b_idx;
            out_m     <= m_idx;
            state     <= OUT;
          end else begin
            j <= j + JW'(LANES);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            j         <= '0;
            if (m_idx == M_LAST) begin
              m_idx <= '0;
              if (b_idx == B_LAST) begin
                b_idx <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                b_idx <= b_idx + BW'(1);
                state <= MAC;
              end
            end else begin
              m_idx <= m_idx + MW'(1);
              state <= MAC;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: scoreboard queues filled at stimulus time, monitors pop on handshakes.
// Two instances: LANES=2 (K=2) and LANES=4 (K=1), sharing operands and reset.
// Expected values are hand-computed per directed vector.
module tb_dense_layer_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [15:0] w  [3][4];
  logic signed [15:0] in [2][4];

  logic               start1 = 1'b0, ordy1 = 1'b1;
  logic               busy1, ov1, done1;
  logic signed [31:0] od1;
  logic [0:0]         ob1;
  logic [1:0]         om1;

  logic               start2 = 1'b0, ordy2 = 1'b1;
  logic               busy2, ov2, done2;
  logic signed [31:0] od2;
  logic [0:0]         ob2;
  logic [1:0]         om2;

  dense_layer_seq #(.B(2), .M(3), .N(4), .WIDTH(16), .LANES(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .weights(w), .inputs(in),
    .busy(busy1), .out_valid(ov1), .out_ready(ordy1), .out_data(od1),
    .out_b(ob1), .out_m(om1), .done(done1));

  dense_layer_seq #(.B(2), .M(3), .N(4), .WIDTH(16), .LANES(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .weights(w), .inputs(in),
    .busy(busy2), .out_valid(ov2), .out_ready(ordy2), .out_data(od2),
    .out_b(ob2), .out_m(om2), .done(done2));

  typedef struct {longint d; int b; int m;} exp_t;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  longint exp_tab [6];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic longint relu(input longint v);
`ifdef DENSE_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  // Scoreboard monitors: compare each accepted element against the queue head.
  always @(negedge clk) begin
    if (!rst && ov1 && ordy1) begin
      if (q1.size() == 0) chk("sb1_unexpected", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("sb1_data", od1, e1.d);
        chk("sb1_b", ob1, e1.b);
        chk("sb1_m", om1, e1.m);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov2 && ordy2) begin
      if (q2.size() == 0) chk("sb2_unexpected", 1, 0);
      else begin
        e2 = q2.pop_front();
        chk("sb2_data", od2, e2.d);
        chk("sb2_b", ob2, e2.b);
        chk("sb2_m", om2, e2.m);
      end
    end
  end

  task automatic set_all(input logic signed [15:0] wv, input logic signed [15:0] iv);
    for (int m = 0; m < 3; m++) for (int n = 0; n < 4; n++) w[m][n] = wv;
    for (int b = 0; b < 2; b++) for (int n = 0; n < 4; n++) in[b][n] = iv;
  endtask

  task automatic set_basic();
    set_all(16'sd1, 16'sd0);
    for (int b = 0; b < 2; b++) for (int n = 0; n < 4; n++) in[b][n] = 16'(n + 1);
    for (int k = 0; k < 6; k++) exp_tab[k] = 10;
  endtask

  task automatic run_job(input string tag, input bit bp, input bit mid_start, input int exp_len);
    int t, tdone, bad;
    bit got;
    for (int b = 0; b < 2; b++)
      for (int m = 0; m < 3; m++)
        q1.push_back('{relu(exp_tab[b*3+m]), b, m});
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 t = cyc; start1 = 1'b0;
    if (mid_start) begin
      repeat (3) @(posedge clk);
      #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
    end
    if (bp) begin
      repeat (5) @(posedge clk);
      #1 ordy1 = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!(ov1 && ob1 == 1'b0 && om1 == 2'd1 && od1 == 32'(relu(exp_tab[1])))) bad++;
        @(posedge clk);
      end
      #1 ordy1 = 1'b1;
      chk({tag, "_bp_hold"}, bad, 0);
    end
    got = 1'b0;
    tdone = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done1) begin got = 1'b1; tdone = cyc; end
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_job_len"}, tdone - t + 1, exp_len);
    chk({tag, "_q_empty"}, q1.size(), 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {done1, busy1}, 2'b00);
    if (mid_start) begin
      bad = 0;
      repeat (4) begin @(negedge clk); if (busy1 || ov1) bad++; end
      chk({tag, "_no_queued_start"}, bad, 0);
    end
  endtask

  initial begin
    int t, tdone, bad;
    bit got;
    set_basic();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_valid", ov1, 0);
    chk("rst_done", done1, 0);
    chk("rst_data", od1, 0);
    chk("rst_idx", {ob1, om1}, 0);

    // Basic: all results 10, length 6*3+1.
    run_job("basic", 1'b0, 1'b0, 19);

    // Distinct per-element values.
    set_all(16'sd0, 16'sd0);
    w[0][0] = 16'sd1;
    w[1][1] = 16'sd1;
    for (int n = 0; n < 4; n++) w[2][n] = 16'sd1;
    for (int n = 0; n < 4; n++) in[0][n] = 16'(n + 1);
    in[1][0] = -16'sd5; in[1][1] = 16'sd6; in[1][2] = 16'sd7; in[1][3] = -16'sd8;
    exp_tab[0] = 1;  exp_tab[1] = 2; exp_tab[2] = 10;
    exp_tab[3] = -5; exp_tab[4] = 6; exp_tab[5] = 0;
    run_job("mixed", 1'b0, 1'b0, 19);

    // Positive saturation: 4 * 2^30 clamps high.
    set_all(16'sh8000, 16'sh8000);
    for (int k = 0; k < 6; k++) exp_tab[k] = 64'sd2147483647;
    run_job("sat_pos", 1'b0, 1'b0, 19);

    // Negative saturation: 4 * (-2^30 + 2^15) clamps low.
    set_all(16'sh8000, 16'sh7FFF);
    for (int k = 0; k < 6; k++) exp_tab[k] = -64'sd2147483648;
    run_job("sat_neg", 1'b0, 1'b0, 19);

    // Small negative result: -4, or 0 with ReLU.
    set_all(-16'sd1, 16'sd1);
    for (int k = 0; k < 6; k++) exp_tab[k] = -4;
    run_job("neg4", 1'b0, 1'b0, 19);

    // Backpressure at element (0,1) for 20 cycles adds exactly 20 cycles.
    set_basic();
    run_job("bp", 1'b1, 1'b0, 39);

    // Start pulse mid-job is ignored and not queued.
    run_job("busy_start", 1'b0, 1'b1, 19);

    // Reset during MAC aborts: no valid, no done.
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy1, 0);
    chk("abort_valid", ov1, 0);
    bad = 0;
    repeat (30) begin @(negedge clk); if (ov1 || done1 || busy1) bad++; end
    chk("abort_quiet", bad, 0);
    run_job("after_abort", 1'b0, 1'b0, 19);

    // K=1 instance: first valid one cycle after the start edge, job length 13.
    for (int b = 0; b < 2; b++)
      for (int m = 0; m < 3; m++)
        q2.push_back('{relu(64'sd10), b, m});
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 t = cyc; start2 = 1'b0;
    @(negedge clk);
    chk("k1_valid_t0", ov2, 0);
    @(negedge clk);
    chk("k1_valid_t1", ov2, 1);
    got = 1'b0;
    tdone = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (done2) begin got = 1'b1; tdone = cyc; end
      else @(negedge clk);
    end
    chk("k1_done_seen", got, 1);
    chk("k1_job_len", tdone - t + 1, 13);
    chk("k1_q_empty", q2.size(), 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
